// File: rtl/pe_feeder.sv
// pe_feeder: buffers K operand pairs (A/B) and streams them to an
// accumulating PE as registered mat1/mat2, with stall and zero-drain.
//
// Ports:
//   clk, rst (async, active-low)
//   wr_en, wr_sel, wr_addr, wr_data : buffer load port (IDLE/DONE only)
//   start                           : run request, level-sampled
//   stall                           : freeze and present zeros
//   mat1, mat2, feed_valid          : registered operand pair to the PE
//   busy, done                      : run status / end-of-run pulse
//
// Parameters: DATA_TYPE (3'b011 int8, 3'b100 int16, 3'b101 int32,
// other raw), K (pairs per run), FLUSH_CYC (zero drain cycles).
//
// Build option: define FEEDER_AUTO_RESTART_EN to let start in the DONE
// cycle launch the next run directly without passing through IDLE.

module pe_feeder #(
    parameter logic [2:0] DATA_TYPE = 3'b011,
    parameter int         K         = 4,
    parameter int         FLUSH_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_sel,
    input  logic [$clog2(K)-1:0] wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 start,
    input  logic                 stall,
    output logic [31:0]          mat1,
    output logic [31:0]          mat2,
    output logic                 feed_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int AW = $clog2(K);
    localparam int IW = $clog2(K + 1);
    localparam int FW = $clog2(FLUSH_CYC + 1);

    localparam logic [IW-1:0] IDX_END = IW'(K);
    localparam logic [FW-1:0] FL_END  = FW'(FLUSH_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [FW-1:0] fcnt;

    logic [31:0] a_mem [K];
    logic [31:0] b_mem [K];

    logic wr_ok;

    function automatic logic [31:0] ext(input logic [31:0] v);
        logic [31:0] r;
        case (DATA_TYPE)
            3'b011:  r = {{24{v[7]}}, v[7:0]};
            3'b100:  r = {{16{v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    // Buffers may only change while no run is reading them.
    assign wr_ok = wr_en
                 && (state == S_IDLE || state == S_DONE)
                 && (int'(wr_addr) < K);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < K; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (wr_ok) begin
            if (wr_sel)
                b_mem[wr_addr] <= wr_data;
            else
                a_mem[wr_addr] <= wr_data;
        end
    end

    // Outputs are registered: the value loaded at an edge is what the
    // PE sees for the whole following cycle. A launch therefore loads
    // pair 0 on the accepting edge and leaves idx pointing at pair 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            fcnt       <= '0;
            mat1       <= '0;
            mat2       <= '0;
            feed_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            mat1       <= '0;
            mat2       <= '0;
            feed_valid <= 1'b0;
            done       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (!wr_en && start) begin
                        state      <= S_FEED;
                        mat1       <= ext(a_mem[0]);
                        mat2       <= ext(b_mem[0]);
                        feed_valid <= 1'b1;
                        busy       <= 1'b1;
                        idx        <= IW'(1);
                    end
                end
                S_FEED: begin
                    if (!stall) begin
                        if (idx == IDX_END) begin
                            state <= S_FLUSH;
                            fcnt  <= FW'(1);
                        end else begin
                            mat1       <= ext(a_mem[idx[AW-1:0]]);
                            mat2       <= ext(b_mem[idx[AW-1:0]]);
                            feed_valid <= 1'b1;
                            idx        <= idx + IW'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    if (!stall) begin
                        if (fcnt == FL_END) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            fcnt <= fcnt + FW'(1);
                        end
                    end
                end
                S_DONE: begin
                    idx  <= '0;
                    fcnt <= '0;
`ifdef FEEDER_AUTO_RESTART_EN
                    if (!wr_en && start) begin
                        state      <= S_FEED;
                        mat1       <= ext(a_mem[0]);
                        mat2       <= ext(b_mem[0]);
                        feed_valid <= 1'b1;
                        busy       <= 1'b1;
                        idx        <= IW'(1);
                    end else begin
                        state <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: scoreboard bench for pe_feeder (int8, K=4, FLUSH_CYC=2).
// Expected cycles are queued from the run timeline, then popped per cycle.

module tb_pe_feeder;

    localparam int K  = 4;
    localparam int FL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        wr_sel;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic        stall;
    logic [31:0] mat1;
    logic [31:0] mat2;
    logic        feed_valid;
    logic        busy;
    logic        done;

    pe_feeder #(
        .DATA_TYPE (3'b011),
        .K         (K),
        .FLUSH_CYC (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stall      (stall),
        .mat1       (mat1),
        .mat2       (mat2),
        .feed_valid (feed_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] m1;
        logic [31:0] m2;
        logic        v;
        logic        b;
        logic        d;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ma [K];
    logic [31:0] mb [K];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    string       tname = "init";
    longint      acc   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] sx8(input logic [31:0] v);
        return {{24{v[7]}}, v[7:0]};
    endfunction

    task automatic push(input logic [31:0] m1, input logic [31:0] m2,
                        input logic v, input logic b, input logic d);
        exp_t e;
        e.m1 = m1; e.m2 = m2; e.v = v; e.b = b; e.d = d;
        exp_q.push_back(e);
    endtask

    // One clock: inputs applied for the next edge, outputs checked at
    // the following falling edge against the head of the scoreboard.
    task automatic cyc(input logic s, input logic sl,
                       input logic we = 1'b0, input logic sel = 1'b0,
                       input logic [1:0] a = 2'd0,
                       input logic [31:0] d = 32'd0);
        exp_t e;
        start = s; stall = sl;
        wr_en = we; wr_sel = sel; wr_addr = a; wr_data = d;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; stall = 1'b0; wr_en = 1'b0;
        cyc_n++;
        acc += longint'($signed(mat1)) * longint'($signed(mat2));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s c%0d ops", tname, cyc_n),
                {mat1, mat2}, {e.m1, e.m2});
            chk($sformatf("%s c%0d flags", tname, cyc_n),
                {61'd0, feed_valid, busy, done}, {61'd0, e.v, e.b, e.d});
        end
    endtask

    task automatic wr(input logic sel, input logic [1:0] a,
                      input logic [31:0] d);
        cyc(1'b0, 1'b0, 1'b1, sel, a, d);
        if (sel) mb[a] = d;
        else     ma[a] = d;
    endtask

    // Timeline of one run: pairs, then FL zero cycles, stall cycle sc
    // inserted as a zero cycle, then the done cycle (+ optional idle).
    task automatic exp_run(input int sc, input bit idle, output int len);
        int n = 1;
        int p = 0;
        int f = 0;
        while (p < K || f < FL) begin
            if (n == sc) begin
                push(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
            end else if (p < K) begin
                push(sx8(ma[p]), sx8(mb[p]), 1'b1, 1'b1, 1'b0);
                p++;
            end else begin
                push(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
                f++;
            end
            n++;
        end
        push(32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        len = n + (idle ? 1 : 0);
    endtask

    task automatic run(input int sc);
        int len;
        cyc_n = 0;
        exp_run(sc, 1'b1, len);
        for (int c = 0; c < len; c++)
            cyc(c == 0, c + 1 == sc);
    endtask

    initial begin
        int len;
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 32'd0;
        for (int i = 0; i < K; i++) begin
            ma[i] = 32'd0; mb[i] = 32'd0;
        end

        @(negedge clk);
        tname = "reset";
        chk("reset ops", {mat1, mat2}, 64'd0);
        chk("reset flags", {61'd0, feed_valid, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        wr(1'b0, 2'd0, 32'd2);  wr(1'b0, 2'd1, 32'd10);
        wr(1'b0, 2'd2, 32'd7);  wr(1'b0, 2'd3, 32'd5);
        wr(1'b1, 2'd0, 32'd3);  wr(1'b1, 2'd1, 32'd11);
        wr(1'b1, 2'd2, 32'd8);  wr(1'b1, 2'd3, 32'd6);

        tname = "basic";
        acc = 0;
        run(0);
        chk("basic pe_sum", 64'(acc), 64'd202);

        tname = "stall";
        run(2);

        tname = "busyprot";
        cyc_n = 0;
        exp_run(0, 1'b1, len);
        for (int c = 0; c < len; c++) begin
            if (c == 1) cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 32'd99);
            else        cyc(c == 0, 1'b0);
        end
        tname = "busyprot2";
        run(0);

        tname = "wr_prio";
        cyc_n = 0;
        push(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        push(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 32'd20);
        ma[2] = 32'd20;
        cyc(1'b0, 1'b0);

        tname = "int8";
        wr(1'b0, 2'd0, 32'h0000_00FF);
        wr(1'b1, 2'd0, 32'h0000_0180);
        cyc_n = 0;
        exp_run(0, 1'b1, len);
        cyc(1'b1, 1'b0);
        chk("int8 mat1", {32'd0, mat1}, {32'd0, 32'hFFFF_FFFF});
        chk("int8 mat2", {32'd0, mat2}, {32'd0, 32'hFFFF_FF80});
        for (int c = 1; c < len; c++)
            cyc(1'b0, 1'b0);

        tname = "restart";
        cyc_n = 0;
        exp_run(0, 1'b0, len);
`ifndef FEEDER_AUTO_RESTART_EN
        push(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
`endif
        for (int c = 0; c < len; c++)
            cyc(1'b1, 1'b0);
`ifndef FEEDER_AUTO_RESTART_EN
        cyc(1'b1, 1'b0);
`endif
        exp_run(0, 1'b1, len);
        cyc(1'b1, 1'b0);
        for (int c = 1; c < len; c++)
            cyc(1'b0, 1'b0);

        tname = "midrst";
        cyc_n = 0;
        push(sx8(ma[0]), sx8(mb[0]), 1'b1, 1'b1, 1'b0);
        push(sx8(ma[1]), sx8(mb[1]), 1'b1, 1'b1, 1'b0);
        push(sx8(ma[2]), sx8(mb[2]), 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst ops", {mat1, mat2}, 64'd0);
        chk("midrst flags", {61'd0, feed_valid, busy, done}, 64'd0);
        for (int i = 0; i < K; i++) begin
            ma[i] = 32'd0; mb[i] = 32'd0;
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            push(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0);
        end
        tname = "postrst";
        run(0);

        chk("queue drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter DATA_TYPE, default 3'b011, operand type code: 3'b011 int8, 3'b100 int16, 3'b101 int32; any other code is raw 32-bit.
REQ-002 SHALL have parameter K, default 4, operand pairs per run (2..16).
REQ-003 SHALL have parameter FLUSH_CYC, default 2, zero-operand drain cycles after the last pair (1..8).
REQ-004 SHALL have port clk  input  1  sole clock; all registers on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en  input  1  buffer write strobe.
REQ-007 SHALL have port wr_sel  input  1  buffer select: 0 = A (mat1), 1 = B (mat2).
REQ-008 SHALL have port wr_addr  input  $clog2(K)  buffer entry index.
REQ-009 SHALL have port wr_data  input  32  buffer write data.
REQ-010 SHALL have port start  input  1  run request, level-sampled.
REQ-011 SHALL have port stall  input  1  hold request from downstream.
REQ-012 SHALL have port mat1  output  32  row operand to PE, registered.
REQ-013 SHALL have port mat2  output  32  column operand to PE, registered.
REQ-014 SHALL have port feed_valid  output  1  high when mat1/mat2 carry a real pair.
REQ-015 SHALL have port busy  output  1  high in FEED and FLUSH.
REQ-016 SHALL have port done  output  1  one-cycle end-of-run pulse.

Function
REQ-017 SHALL implement FSM states IDLE, FEED, FLUSH, DONE.
REQ-018 SHALL write wr_data to A[wr_addr] or B[wr_addr] on an edge with wr_en=1, only in IDLE or DONE; writes in FEED/FLUSH are dropped. Out-of-range wr_addr is ignored.
REQ-019 SHALL accept start only in IDLE with wr_en=0; wr_en=1 with start in the same cycle gives the write priority and ignores start.
REQ-020 SHALL ignore start in FEED and FLUSH.
REQ-021 SHALL, after start is accepted at edge t0, present pair i (A[i], B[i]) in unstalled feed cycle i+1, i = 0..K-1, with feed_valid=1.
REQ-022 SHALL drive mat1=mat2=0 and feed_valid=0 for FLUSH_CYC unstalled cycles after the last pair.
REQ-023 SHALL enter DONE after FLUSH, with done=1 and busy=0 for exactly one cycle, then go to IDLE. Unstalled run: done in cycle K+FLUSH_CYC+1.
REQ-024 SHALL, on any cycle with stall=1 in FEED or FLUSH, freeze state and index and drive mat1=mat2=0 and feed_valid=0, so the accumulating PE adds nothing. stall SHALL be ignored in IDLE and DONE.
REQ-025 SHALL sign-extend each operand from its low 8 bits (int8) or low 16 bits (int16) to 32 bits, and pass it unchanged for int32 and raw.
REQ-026 SHALL drive mat1=mat2=0 and feed_valid=0 in IDLE and DONE.

Reset
REQ-027 SHALL, while rst=0, immediately force state IDLE, index 0, all A/B entries 0, and mat1, mat2, feed_valid, busy, done to 0.
REQ-028 SHALL NOT pulse done when reset interrupts a run; operation resumes in IDLE on the first edge after rst=1.

Configuration
REQ-029 SHALL, with macro FEEDER_AUTO_RESTART_EN defined, go from DONE directly to FEED when start=1 and wr_en=0 in the DONE cycle, presenting A[0]/B[0] in the next cycle.
REQ-030 SHALL, without FEEDER_AUTO_RESTART_EN, always go from DONE to IDLE; start is then sampled only in IDLE.

Verification (DATA_TYPE=3'b011, K=4, FLUSH_CYC=2)
REQ-031 SHALL cover the basic run: load A={2,10,7,5}, B={3,11,8,6}, start -> cycles 1-4 pairs (2,3),(10,11),(7,8),(5,6) with feed_valid=1; cycles 5-6 zeros; done in cycle 7; attached PE sum 202.
REQ-032 SHALL cover int8 extension: A[0]=32'h000000FF, B[0]=32'h00000180 -> mat1=32'hFFFFFFFF, mat2=32'hFFFFFF80 in cycle 1.
REQ-033 SHALL cover stall: stall=1 in cycle 2 only -> cycle 2 zeros with feed_valid=0, pair (10,11) in cycle 3, done in cycle 8.
REQ-034 SHALL cover busy protection: start and a write of A[1]=99 in cycle 2 -> run unchanged, A[1] stays 10 on the next run.
REQ-035 SHALL cover mid-run reset: rst=0 in cycle 3 -> outputs 0 immediately, no done, next run (new start, no reload) feeds zeros.
REQ-036 SHALL cover restart: start held high through done -> with macro, A[0] in the cycle after done; without, one IDLE cycle, then A[0] one cycle later.
